// File: rtl/video_pkg.sv
// video_pkg: shared coefficients, blanking codes and pixel types for the YCbCr 4:2:2 path.
package video_pkg;
    localparam int PIPE_LAT = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Row-major {Y, Cb, Cr} x {R, G, B}
    localparam logic signed [8:0] COEF_LIM [9] = '{
        9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94, -9'sd18
    };
    localparam logic signed [8:0] COEF_FULL [9] = '{
        9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21
    };

    localparam logic signed [17:0] Y_OFF_LIM  = 18'sd16;
    localparam logic signed [17:0] Y_OFF_FULL = 18'sd0;
    localparam logic signed [17:0] C_OFF      = 18'sd128;
    localparam logic signed [17:0] ROUND      = 18'sd128;

    localparam logic [15:0] BLANK_LIM  = 16'h1080;
    localparam logic [15:0] BLANK_FULL = 16'h0080;

    function automatic logic signed [17:0] mul8x9(input logic [7:0] c, input logic signed [8:0] k);
        logic signed [17:0] a;
        logic signed [17:0] b;
        a = {10'd0, c};
        b = {{9{k[8]}}, k};
        return a * b;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        return v < 0 ? 8'd0 : (v > 18'sd255 ? 8'd255 : v[7:0]);
    endfunction
endpackage

// File: rtl/rgb2ycbcr_csc.sv
// rgb2ycbcr_csc: three-stage RGB888 to YCbCr colour-space converter (products, sums, round/offset/clamp).
module rgb2ycbcr_csc
    import video_pkg::*;
#(
    parameter bit LIMITED_RANGE = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  rgb888_t    rgb,
    output logic [7:0] y,
    output logic [7:0] cb,
    output logic [7:0] cr
);
    localparam logic signed [17:0] Y_OFF = LIMITED_RANGE ? Y_OFF_LIM : Y_OFF_FULL;

    logic        [7:0]  ch   [3];
    logic signed [17:0] prod [9];
    logic signed [17:0] sum  [3];

    assign ch = '{rgb.r, rgb.g, rgb.b};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            prod <= '{default: '0};
            sum  <= '{default: '0};
            y    <= '0;
            cb   <= '0;
            cr   <= '0;
        end else begin
            for (int i = 0; i < 9; i++)
                prod[i] <= mul8x9(ch[i % 3], LIMITED_RANGE ? COEF_LIM[i] : COEF_FULL[i]);
            for (int j = 0; j < 3; j++)
                sum[j] <= prod[3*j] + prod[3*j+1] + prod[3*j+2] + ROUND;
            // Arithmetic shift floors negative chroma sums before the offset
            y  <= clamp8((sum[0] >>> 8) + Y_OFF);
            cb <= clamp8((sum[1] >>> 8) + C_OFF);
            cr <= clamp8((sum[2] >>> 8) + C_OFF);
        end
    end
endmodule

// File: rtl/ycbcr422_formatter.sv
// ycbcr422_formatter: RGB888 to co-sited YCbCr 4:2:2 for the HDMI encoder, 4-cycle latency on data and syncs.
module ycbcr422_formatter
    import video_pkg::*;
#(
    parameter bit LIMITED_RANGE = 1'b1,
    parameter bit CB_FIRST      = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        data_enable,
    input  logic [23:0] rgb_data,
    output logic [15:0] hdmi_d,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic        hdmi_de
);
    localparam logic [15:0] BLANK = LIMITED_RANGE ? BLANK_LIM : BLANK_FULL;

    logic [7:0]          y, cb, cr, c_first, c_second, c_hold;
    logic [PIPE_LAT-2:0] hs_d, vs_d, de_d;
    logic                phase, cur_phase, de3;

    rgb2ycbcr_csc #(.LIMITED_RANGE(LIMITED_RANGE)) u_csc (
        .clk_in (clk_in),
        .reset  (reset),
        .rgb    (rgb888_t'(rgb_data)),
        .y      (y),
        .cb     (cb),
        .cr     (cr)
    );

    // de3 lines up with the converter's stage-3 output; hdmi_de is the same flag one cycle later
    always_comb begin
        de3       = de_d[PIPE_LAT-2];
        cur_phase = (de3 && hdmi_de) ? ~phase : 1'b0;
        c_first   = CB_FIRST ? cb : cr;
        c_second  = CB_FIRST ? cr : cb;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hs_d       <= '0;
            vs_d       <= '0;
            de_d       <= '0;
            phase      <= 1'b0;
            c_hold     <= '0;
            hdmi_d     <= '0;
            hdmi_hsync <= 1'b0;
            hdmi_vsync <= 1'b0;
            hdmi_de    <= 1'b0;
        end else begin
            hs_d       <= {hs_d[PIPE_LAT-3:0], hsync};
            vs_d       <= {vs_d[PIPE_LAT-3:0], vsync};
            de_d       <= {de_d[PIPE_LAT-3:0], data_enable};
            phase      <= de3 & cur_phase;
            c_hold     <= (de3 && !cur_phase) ? c_second : c_hold;
            hdmi_d     <= !de3 ? BLANK : {y, cur_phase ? c_hold : c_first};
            hdmi_hsync <= hs_d[PIPE_LAT-2];
            hdmi_vsync <= vs_d[PIPE_LAT-2];
            hdmi_de    <= de3;
        end
    end
endmodule

// File: tb/tb_ycbcr422_formatter.sv
// tb_ycbcr422_formatter: random and directed checks of three formatter configurations against a pixel-stream model.
module tb_ycbcr422_formatter;
    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b0, vsync = 1'b0, data_enable = 1'b0;
    logic [23:0] rgb_data = '0;
    logic [15:0] d_lim, d_full, d_swap;
    logic        hs_lim, vs_lim, de_lim, hs_full, vs_full, de_full, hs_swap, vs_swap, de_swap;

    ycbcr422_formatter #(.LIMITED_RANGE(1'b1), .CB_FIRST(1'b1)) u_lim (
        .clk_in(clk_in), .reset(reset), .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
        .rgb_data(rgb_data), .hdmi_d(d_lim), .hdmi_hsync(hs_lim), .hdmi_vsync(vs_lim), .hdmi_de(de_lim)
    );
    ycbcr422_formatter #(.LIMITED_RANGE(1'b0), .CB_FIRST(1'b1)) u_full (
        .clk_in(clk_in), .reset(reset), .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
        .rgb_data(rgb_data), .hdmi_d(d_full), .hdmi_hsync(hs_full), .hdmi_vsync(vs_full), .hdmi_de(de_full)
    );
    ycbcr422_formatter #(.LIMITED_RANGE(1'b0), .CB_FIRST(1'b0)) u_swap (
        .clk_in(clk_in), .reset(reset), .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
        .rgb_data(rgb_data), .hdmi_d(d_swap), .hdmi_hsync(hs_swap), .hdmi_vsync(vs_swap), .hdmi_de(de_swap)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0] d0, d1, d2;
        logic        hs, vs, de;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0, errors = 0, cyc = 0, run_idx = 0;
    logic        prev_de = 1'b0;
    logic [7:0]  held [3];
    logic [15:0] obs0 [int];
    logic [15:0] obs1 [int];
    logic [15:0] obs2 [int];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        return v < 0 ? 8'd0 : (v > 255 ? 8'd255 : 8'(v));
    endfunction

    // {Y, Cb, Cr} straight from the conversion equations with integer arithmetic
    function automatic logic [23:0] csc(input bit lim, input logic [23:0] p);
        int r, g, b, y, cb, cr;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        if (lim) begin
            y  = 16 + ((66*r + 129*g + 25*b + 128) >>> 8);
            cb = 128 + ((-38*r - 74*g + 112*b + 128) >>> 8);
            cr = 128 + ((112*r - 94*g - 18*b + 128) >>> 8);
        end else begin
            y  = (77*r + 150*g + 29*b + 128) >>> 8;
            cb = 128 + ((-43*r - 85*g + 128*b + 128) >>> 8);
            cr = 128 + ((128*r - 107*g - 21*b + 128) >>> 8);
        end
        return {sat(y), sat(cb), sat(cr)};
    endfunction

    // Pixel position within the active run decides even/odd; odd pixels reuse the even pixel's other chroma
    task automatic model(input logic de, input logic hs, input logic vs, input logic [23:0] p);
        logic [15:0] dv [3];
        logic [23:0] c;
        logic [7:0]  first, second;
        run_idx = de ? (prev_de ? run_idx + 1 : 0) : 0;
        for (int k = 0; k < 3; k++) begin
            c      = csc(k == 0, p);
            first  = (k != 2) ? c[15:8] : c[7:0];
            second = (k != 2) ? c[7:0] : c[15:8];
            if (!de)
                dv[k] = (k == 0) ? 16'h1080 : 16'h0080;
            else if (run_idx % 2 == 0) begin
                dv[k]   = {c[23:16], first};
                held[k] = second;
            end else
                dv[k] = {c[23:16], held[k]};
        end
        prev_de = de;
        expq.push_back('{dv[0], dv[1], dv[2], hs, vs, de});
    endtask

    task automatic reset_model();
        expq.delete();
        run_idx = 0;
        prev_de = 1'b0;
        for (int i = 0; i < 3; i++)
            expq.push_back('{16'h1080, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic tick(input logic de, input logic hs, input logic vs, input logic [23:0] p);
        exp_t e;
        data_enable = de;
        hsync = hs;
        vsync = vs;
        rgb_data = p;
        @(posedge clk_in);
        model(de, hs, vs, p);
        #1;
        cyc++;
        obs0[cyc] = d_lim;
        obs1[cyc] = d_full;
        obs2[cyc] = d_swap;
        e = expq.pop_front();
        check("d_lim", d_lim, e.d0);
        check("d_full", d_full, e.d1);
        check("d_swap", d_swap, e.d2);
        check("hsync", {13'd0, hs_lim, hs_full, hs_swap}, {13'd0, e.hs, e.hs, e.hs});
        check("vsync", {13'd0, vs_lim, vs_full, vs_swap}, {13'd0, e.vs, e.vs, e.vs});
        check("de", {13'd0, de_lim, de_full, de_swap}, {13'd0, e.de, e.de, e.de});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d"}, d_lim | d_full | d_swap, 16'h0000);
        check({tag, "_sync"}, {10'd0, hs_lim, vs_lim, hs_full, vs_full, hs_swap, vs_swap}, 16'h0000);
        check({tag, "_de"}, {13'd0, de_lim, de_full, de_swap}, 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        int s;
        logic [15:0] red_seq [4];
        red_seq = '{16'h525A, 16'h52F0, 16'h525A, 16'h52F0};
        repeat (2) @(posedge clk_in);
        #1 check_zero("reset");
        @(negedge clk_in);
        reset = 1'b0;
        reset_model();
        idle(4);

        // White then black in one run
        s = cyc + 1;
        tick(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        tick(1'b1, 1'b0, 1'b0, 24'h000000);
        idle(5);
        check("white_pre", obs0[s+2], 16'h1080);
        check("white", obs0[s+3], 16'hEB80);
        check("black", obs0[s+4], 16'h1080);

        // Four red pixels
        s = cyc + 1;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        idle(4);
        for (int i = 0; i < 4; i++) check("red_line", obs0[s+3+i], red_seq[i]);

        // Two blue pixels, full range in both chroma orders
        s = cyc + 1;
        tick(1'b1, 1'b0, 1'b0, 24'h0000FF);
        tick(1'b1, 1'b0, 1'b0, 24'h0000FF);
        idle(4);
        check("blue_full0", obs1[s+3], 16'h1DFF);
        check("blue_full1", obs1[s+4], 16'h1D6B);
        check("blue_swap0", obs2[s+3], 16'h1D6B);
        check("blue_swap1", obs2[s+4], 16'h1DFF);

        // Odd-length lines restart on Cb
        s = cyc + 1;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
            idle(2);
        end
        idle(2);
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 3; i++) check("odd_line", obs0[s+3+5*l+i], red_seq[i]);

        // DE glitch mid-line
        s = cyc + 1;
        tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        tick(1'b0, 1'b0, 1'b0, 24'hFF0000);
        tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        idle(4);
        check("glitch_restart", obs0[s+7], 16'h525A);
        check("glitch_next", obs0[s+8], 16'h52F0);

        // Random syncs and DE with fixed colour, then fully random pixels
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 24'h3C9A51);
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 24'($urandom));

        // Reset pulse in the middle of an active line
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 24'($urandom));
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk_in);
        #1 check_zero("held_reset");
        @(negedge clk_in);
        reset = 1'b0;
        reset_model();
        s = cyc + 1;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 24'hFF0000);
        idle(4);
        check("post_reset_wait", obs0[s+2], 16'h1080);
        for (int i = 0; i < 4; i++) check("post_reset", obs0[s+3+i], red_seq[i]);

        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 24'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
